soc_system_pio_edge_ctrl: RTL and testbench
===========================================

Name: soc_system_pio_edge_ctrl

Overview:
- Avalon-MM slave controller for an 8-bit PIO input. Sequences raw pin sampling through a synchronizer, prescaled debounce and per-bit edge capture, and raises an interrupt.
- Sits between board inputs and the Nios CPU. Replaces direct raw-pin reads with a debounced, interrupt-capable view.
- Register map, word addressed: 0 DATA, 1 IRQ_MASK, 2 EDGE_CAP, 3 DB_CFG.

Parameters:
- WIDTH, 8, number of input bits.
- PRESCALE, 500, clk cycles per debounce sample tick; must be ≥ 2.
- EDGE_TYPE, 2, capture mode: 0 = rising, 1 = falling, 2 = any edge.
- DB_RESET, 4'd3, reset value of the DB_CFG threshold.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous raw pins.
- irq  out  1  level interrupt: high when any masked edge bit is set.

Behaviour:
- Reset values:
  - readdata = 0, irq = 0, IRQ_MASK = 0, EDGE_CAP = 0, DB_CFG = DB_RESET.
  - Debounced value = 0, all per-bit counters = 0, prescaler = 0.
  - Synchronizer flops = 0.
  - reset mid-debounce or mid-count discards all progress.
- Synchronizer:
  - 2-flop per bit on in_port, giving sync_in.
  - Latency: 2 clk from pin to sync_in.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick is asserted for exactly one clk when the count equals PRESCALE-1.
- Debounce, per bit, evaluated only on tick. thr = DB_CFG[3:0], with 0 treated as 1.
  - sync_in == deb: cnt <= 0.
  - sync_in != deb and cnt+1 == thr: deb <= sync_in, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - cnt is 4 bits and never exceeds 15.
  - A glitch shorter than thr ticks never changes deb.
- Edge detect:
  - deb_q is deb delayed 1 clk.
  - rise = deb & ~deb_q; fall = ~deb & deb_q; EDGE_TYPE selects which are captured.
  - A captured edge sets EDGE_CAP[i] in the clk after deb changes.
- EDGE_CAP writes:
  - Write-1-to-clear, on bits [WIDTH-1:0].
  - If a set and a clear hit the same bit in the same clk, the set wins and the bit stays 1.
- irq:
  - irq <= |(EDGE_CAP & IRQ_MASK), registered, so 1 clk after EDGE_CAP/IRQ_MASK change.
  - Clearing the last masked edge drops irq the following clk.
- Writes (chipselect & ~write_n):
  - addr 1: IRQ_MASK <= writedata[WIDTH-1:0].
  - addr 2: W1C on EDGE_CAP.
  - addr 3: DB_CFG <= writedata[3:0]; takes effect from the next tick, and in-flight counters are not cleared.
  - addr 0: ignored.
- Reads:
  - readdata is updated every clk (readdata <= zero-extended mux of address); no chipselect qualification is needed, so read latency is 1 clk.
  - addr 0: deb. addr 1: IRQ_MASK. addr 2: EDGE_CAP. addr 3: {28'b0, DB_CFG}.
  - Upper bits always read 0.
  - Reads have no side effects.
- Widths: WIDTH ≤ 32, with unused readdata bits zero.

Decomposition:
- Shared package soc_system_pio_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_DBCFG=3.
  - EDGE_RISE/FALL/ANY encodings.
  - DB_CNT_W=4.
- One natural sub-module: soc_system_pio_debounce_bit.
  - Inputs: clk, reset, tick, sync_in, thr.
  - Output: deb.
  - Instantiated WIDTH times in a generate loop.
- Prescaler, synchronizer, edge capture and register file live in the top.

Test Plan:
- Reset value check: assert reset 3 clk, then read all 4 addresses. Expect readdata 0, 0, 0, 0x3 and irq = 0.
- Debounce: PRESCALE=4, thr=3, in_port 0x00→0x01 held 12 clk. After the 2-clk synchronizer, DATA reads 0x01 on the 3rd tick. A 1-tick pulse 0x02 leaves DATA at 0x01.
- Edge/irq: EDGE_TYPE=2, IRQ_MASK=0x01, bit0 rises. EDGE_CAP=0x01 and irq=1 1 clk later. Write 0x01 to addr 2 → EDGE_CAP=0, irq=0 next clk.
- Masking: IRQ_MASK=0x00, bit3 edge → EDGE_CAP=0x08, irq stays 0. Write mask 0x08 → irq=1 after 1 clk.
- Set/clear collision: W1C of bit0 in the same clk as a new bit0 edge → EDGE_CAP[0] remains 1 and irq stays 1.
- Mid-operation reset: reset asserted while a count is in progress (cnt=2, thr=3) → after release, DATA=0 and the input must again be stable for the full 3 ticks before DATA updates.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the debounced, edge-capturing PIO slave.
// Register addresses, edge-capture encodings and counter widths.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_DBCFG = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int DB_CNT_W = 4;

endpackage

// File: rtl/soc_system_pio_debounce_bit.sv
// One-bit debouncer: deb follows sync_in only after it has
// differed for thr consecutive sample ticks.
module soc_system_pio_debounce_bit
  import soc_system_pio_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                sync_in,
  input  logic [DB_CNT_W-1:0] thr,
  output logic                deb
);

  logic [DB_CNT_W-1:0] cnt;
  logic [DB_CNT_W-1:0] cnt_inc;
  logic [DB_CNT_W-1:0] thr_eff;

  // A zero threshold behaves like a single-tick threshold.
  assign thr_eff = (thr == '0) ? DB_CNT_W'(1) : thr;
  assign cnt_inc = cnt + DB_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (tick) begin
      if (sync_in == deb) begin
        cnt <= '0;
      end else if (cnt_inc == thr_eff) begin
        deb <= sync_in;
        cnt <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/soc_system_pio_edge_ctrl.sv
// Avalon-MM PIO input slave: synchronizer, prescaled debounce,
// per-bit edge capture with write-1-to-clear and a level irq.
module soc_system_pio_edge_ctrl
  import soc_system_pio_pkg::*;
#(
  parameter int                  WIDTH     = 8,
  parameter int                  PRESCALE  = 500,
  parameter int                  EDGE_TYPE = 2,
  parameter logic [DB_CNT_W-1:0] DB_RESET  = 4'd3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [WIDTH-1:0]    sync1;
  logic [WIDTH-1:0]    sync_in;
  logic [WIDTH-1:0]    deb;
  logic [WIDTH-1:0]    deb_q;
  logic [WIDTH-1:0]    irq_mask;
  logic [WIDTH-1:0]    edge_cap;
  logic [DB_CNT_W-1:0] db_cfg;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;
  logic [WIDTH-1:0]    cap_set;
  logic [WIDTH-1:0]    cap_clr;
  logic [31:0]         rd_nxt;
  logic                wr;
  logic                unused_wd;

  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;
  assign tick      = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      sync1   <= '0;
      sync_in <= '0;
      deb_q   <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      sync1   <= in_port;
      sync_in <= sync1;
      deb_q   <= deb;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    soc_system_pio_debounce_bit u_db (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .sync_in (sync_in[i]),
      .thr     (db_cfg),
      .deb     (deb[i])
    );
  end

  assign rise = deb & ~deb_q;
  assign fall = ~deb & deb_q;

  always_comb begin
    cap_set = rise | fall;
    if (EDGE_TYPE == EDGE_RISE) begin
      cap_set = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      cap_set = fall;
    end
  end

  assign cap_clr = (wr && address == ADDR_EDGE)
                 ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_nxt = '0;
    unique case (1'b1)
      (address == ADDR_DATA):  rd_nxt[WIDTH-1:0] = deb;
      (address == ADDR_MASK):  rd_nxt[WIDTH-1:0] = irq_mask;
      (address == ADDR_EDGE):  rd_nxt[WIDTH-1:0] = edge_cap;
      (address == ADDR_DBCFG): rd_nxt[DB_CNT_W-1:0] = db_cfg;
      default: ;
    endcase
  end

  // Set takes priority over a same-cycle clear so no edge is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cap <= '0;
      db_cfg   <= DB_RESET;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      if (wr && address == ADDR_DBCFG) begin
        db_cfg <= writedata[DB_CNT_W-1:0];
      end
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      readdata <= rd_nxt;
      irq      <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_soc_system_pio_edge_ctrl.sv
// Directed bench for the PIO edge controller with a short
// prescaler so debounce timing can be counted cycle by cycle.
module tb_soc_system_pio_edge_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;

  int total;
  int bad;
  int cyc;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl[19];

  soc_system_pio_edge_ctrl #(
    .WIDTH     (8),
    .PRESCALE  (4),
    .EDGE_TYPE (2),
    .DB_RESET  (4'd3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    repeat (n) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic bus_wr(input logic [1:0] a,
                        input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h00;

    // rst cs wn addr wdata readdata irq
    tbl[0]  = '{1, 0, 1, 2'd0, 32'h0, 32'h0, 0};
    tbl[1]  = '{1, 0, 1, 2'd3, 32'h0, 32'h0, 0};
    tbl[2]  = '{1, 0, 1, 2'd0, 32'h0, 32'h0, 0};
    tbl[3]  = '{0, 0, 1, 2'd0, 32'h0, 32'h0, 0};
    tbl[4]  = '{0, 0, 1, 2'd1, 32'h0, 32'h0, 0};
    tbl[5]  = '{0, 0, 1, 2'd2, 32'h0, 32'h0, 0};
    tbl[6]  = '{0, 0, 1, 2'd3, 32'h0, 32'h3, 0};
    tbl[7]  = '{0, 1, 0, 2'd1, 32'hA5, 32'h0, 0};
    tbl[8]  = '{0, 0, 1, 2'd1, 32'h0, 32'hA5, 0};
    tbl[9]  = '{0, 1, 0, 2'd3, 32'hFFFF_FFF7, 32'h3, 0};
    tbl[10] = '{0, 0, 1, 2'd3, 32'h0, 32'h7, 0};
    tbl[11] = '{0, 1, 0, 2'd0, 32'hFF, 32'h0, 0};
    tbl[12] = '{0, 0, 1, 2'd0, 32'h0, 32'h0, 0};
    tbl[13] = '{0, 1, 0, 2'd2, 32'hFF, 32'h0, 0};
    tbl[14] = '{0, 0, 1, 2'd2, 32'h0, 32'h0, 0};
    tbl[15] = '{0, 0, 0, 2'd1, 32'h0, 32'hA5, 0};
    tbl[16] = '{0, 0, 1, 2'd1, 32'h0, 32'hA5, 0};
    tbl[17] = '{0, 1, 0, 2'd1, 32'hFFFF_FF00, 32'hA5, 0};
    tbl[18] = '{0, 0, 1, 2'd1, 32'h0, 32'h0, 0};

    for (int i = 0; i < 19; i++) begin
      reset      = tbl[i].rst;
      chipselect = tbl[i].cs;
      write_n    = tbl[i].wn;
      address    = tbl[i].addr;
      writedata  = tbl[i].wd;
      step();
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].rd);
      chk($sformatf("tbl%0d_irq", i), {31'b0, irq},
          {31'b0, tbl[i].irq});
    end

    // Debounce, glitch rejection, edge capture, irq and W1C.
    do_reset(3);
    in_port = 8'h01;
    bus_wr(2'd1, 32'h01);
    address = 2'd0;
    run_to(12);
    chk("db_before_3rd_tick", readdata, 32'h0);
    run_to(13);
    chk("db_after_3rd_tick", readdata, 32'h1);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    run_to(14);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    address = 2'd2;
    run_to(15);
    chk("edge_cap_bit0", readdata, 32'h1);
    address = 2'd0;
    run_to(16);
    in_port = 8'h03;
    run_to(20);
    in_port = 8'h01;
    run_to(24);
    bus_wr(2'd2, 32'h01);
    chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
    chk("w1c_rd_old", readdata, 32'h1);
    run_to(26);
    chk("w1c_cleared", readdata, 32'h0);
    chk("w1c_irq_drop", {31'b0, irq}, 32'h0);
    address = 2'd0;
    run_to(30);
    chk("glitch_rejected", readdata, 32'h1);

    // Masked-off edge is captured but holds irq low.
    do_reset(2);
    in_port = 8'h08;
    address = 2'd0;
    run_to(14);
    chk("mask0_irq", {31'b0, irq}, 32'h0);
    address = 2'd2;
    run_to(15);
    chk("mask0_cap", readdata, 32'h8);
    bus_wr(2'd1, 32'h08);
    chk("mask_wr_irq_lag", {31'b0, irq}, 32'h0);
    run_to(17);
    chk("mask_wr_irq", {31'b0, irq}, 32'h1);

    // Clear collides with a new falling edge on bit0.
    do_reset(2);
    in_port = 8'h01;
    bus_wr(2'd1, 32'h01);
    address = 2'd0;
    run_to(16);
    in_port = 8'h00;
    run_to(28);
    chk("coll_deb_still1", readdata, 32'h1);
    bus_wr(2'd2, 32'h01);
    chk("coll_irq_a", {31'b0, irq}, 32'h1);
    run_to(30);
    chk("coll_cap_kept", readdata, 32'h1);
    chk("coll_irq_b", {31'b0, irq}, 32'h1);
    address = 2'd0;
    run_to(31);
    chk("coll_deb_fell", readdata, 32'h0);

    // Threshold of zero acts as one tick.
    do_reset(2);
    in_port = 8'h01;
    bus_wr(2'd3, 32'h0);
    address = 2'd0;
    run_to(4);
    chk("thr0_before", readdata, 32'h0);
    run_to(5);
    chk("thr0_after", readdata, 32'h1);

    // Reset in the middle of a count discards it.
    do_reset(2);
    in_port = 8'h01;
    address = 2'd0;
    run_to(8);
    do_reset(1);
    run_to(12);
    chk("midrst_hold", readdata, 32'h0);
    run_to(13);
    chk("midrst_set", readdata, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
